wbp_watchdog: RTL and testbench
===============================

// Module: wbp_watchdog
// PURPOSE
//  Pipelined Wishbone bus guard between the AXI-lite bridge's WB master port and the
//  downstream WB slave/interconnect. Tracks outstanding requests, caps them at a
//  maximum and blocks acks with no matching request. Aborts any bus cycle that makes no
//  progress for TIMEOUT clocks by returning an error upstream, so stalled slaves cannot hang AXI.
// PARAMETERS
//  AW        26   WB word-address width
//  DW        32   WB data width (sel width DW/8)
//  LGMAXOUT  4    log2 max outstanding requests; cap MAXOUT = 2**LGMAXOUT-1
//  TIMEOUT   1024 no-progress clocks before abort (>=2)
// PORTS
//  i_clk        in   1     clock
//  i_reset      in   1     asynchronous, active-high reset
//  i_wb_cyc/stb/we in 1 each  upstream request (from bridge)
//  i_wb_addr    in   AW    upstream address
//  i_wb_data    in   DW    upstream write data
//  i_wb_sel     in   DW/8  upstream byte selects
//  o_wb_stall   out  1     stall to upstream
//  o_wb_ack     out  1     ack to upstream
//  o_wb_data    out  DW    read data to upstream (= i_dn_data)
//  o_wb_err     out  1     bus error to upstream (slave err or timeout)
//  o_dn_cyc/stb/we out 1 each  downstream request
//  o_dn_addr/o_dn_data/o_dn_sel out AW/DW/DW/8  downstream (= upstream values)
//  i_dn_stall/i_dn_ack/i_dn_err in 1 each  downstream responses
//  i_dn_data    in   DW    downstream read data
//  o_timeout    out  1     one-clock pulse when an abort fires
//  o_outstanding out LGMAXOUT+1  outstanding request count
// BEHAVIOUR
//  Reset (async): state=IDLE, count=0, timer=0, o_timeout=0; all WB outputs low.
//  States IDLE, ACTIVE, ABORT, DRAIN (registered). Data/addr/sel/we always pass through.
//  IDLE: o_dn_cyc=i_wb_cyc. i_wb_cyc high -> ACTIVE (same-cycle stb forwarded).
//  ACTIVE: o_dn_cyc=i_wb_cyc; o_dn_stb=i_wb_stb&&!full; o_wb_stall=i_dn_stall||full
//   (full = count==MAXOUT). Zero-latency pass-through of ack/err, gated by count!=0;
//   ack/err with count==0 is dropped.
//  Count: +1 on o_dn_stb&&!i_dn_stall; -1 on forwarded ack/err; both same clock ->
//   unchanged. Upstream err or i_wb_cyc low -> count=0, timer=0, next IDLE (per-beat
//   responses already in flight are discarded).
//  Timer: cleared on accepted request, forwarded ack/err, or when count==0 and !i_wb_stb;
//   otherwise +1. timer==TIMEOUT-1 while still incrementing -> next ABORT.
//  ABORT (1 clk): o_wb_err=1, o_wb_ack=0, o_dn_cyc=o_dn_stb=0, o_wb_stall=1,
//   o_timeout=1, count=0, timer=0. Next: DRAIN if i_wb_cyc else IDLE.
//  DRAIN: o_dn_cyc=0, o_wb_stall=1, ack/err suppressed; i_wb_cyc low -> IDLE.
//  o_wb_err only asserted with upstream cyc high; never ack and err on same clock
//   (i_dn_ack&&i_dn_err forwards err only, count -1).
//  Reset mid-cycle: outputs low immediately (async), no response issued.
// TESTING
//  1 Single read: stb 1 clk, dn ack 2 clks later, data 32'hDEADBEEF -> o_wb_ack same
//    clk, o_wb_data=32'hDEADBEEF, o_outstanding 0->1->0, no o_timeout.
//  2 Pipelined burst: 20 stbs, dn never stalls, acks delayed 16 -> stall asserted at
//    count=15, all 20 acked in order, max count 15.
//  3 Timeout: TIMEOUT=8, one request, no dn ack -> err+o_timeout 8 clks after accept,
//    o_dn_cyc low that clk, a late dn ack in DRAIN not forwarded.
//  4 Stalled request: i_dn_stall held high, TIMEOUT=8 -> abort after 8 clks, count 0.
//  5 Spurious ack with count=0 -> not forwarded; ack+new stb same clk -> count unchanged.
//  6 i_reset pulsed with 3 outstanding -> all outputs 0 asynchronously, count 0, IDLE.

Source files
------------

// File: rtl/wbp_watchdog.sv
// Pipelined Wishbone bus guard: forwards requests downstream, caps and tracks outstanding
// requests, drops unmatched responses and aborts any cycle that stops making progress.

module wbp_watchdog_checker #(
    parameter int              CW   = 5,
    parameter logic [CW-1:0]   MAXC = 5'd15
) (
    input logic          clk,
    input logic          rst,
    input logic          cyc,
    input logic          ack,
    input logic          err,
    input logic          timeout,
    input logic          dn_cyc,
    input logic [CW-1:0] count
);

    // Bus-protocol invariants on the upstream response and downstream cycle signals
    assert property (@(posedge clk) disable iff (rst) !(ack && err))
        else $error("wbp_watchdog: ack and err asserted together");
    assert property (@(posedge clk) disable iff (rst) (err |-> cyc))
        else $error("wbp_watchdog: err without upstream cycle");
    assert property (@(posedge clk) disable iff (rst) (timeout |-> (!dn_cyc && !ack)))
        else $error("wbp_watchdog: downstream cycle or ack during abort");
    assert property (@(posedge clk) disable iff (rst) (count <= MAXC))
        else $error("wbp_watchdog: outstanding count above cap");

endmodule

module wbp_watchdog #(
    parameter int AW       = 26,
    parameter int DW       = 32,
    parameter int LGMAXOUT = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_wb_cyc,
    input  logic                i_wb_stb,
    input  logic                i_wb_we,
    input  logic [AW-1:0]       i_wb_addr,
    input  logic [DW-1:0]       i_wb_data,
    input  logic [DW/8-1:0]     i_wb_sel,
    output logic                o_wb_stall,
    output logic                o_wb_ack,
    output logic [DW-1:0]       o_wb_data,
    output logic                o_wb_err,
    output logic                o_dn_cyc,
    output logic                o_dn_stb,
    output logic                o_dn_we,
    output logic [AW-1:0]       o_dn_addr,
    output logic [DW-1:0]       o_dn_data,
    output logic [DW/8-1:0]     o_dn_sel,
    input  logic                i_dn_stall,
    input  logic                i_dn_ack,
    input  logic                i_dn_err,
    input  logic [DW-1:0]       i_dn_data,
    output logic                o_timeout,
    output logic [LGMAXOUT:0]   o_outstanding
);

    localparam int                TW         = $clog2(TIMEOUT);
    localparam logic [TW-1:0]     TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]     TIMER_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0]     TIMER_ONE  = TW'(1'b1);
    localparam logic [LGMAXOUT:0] CNT_ZERO   = {(LGMAXOUT+1){1'b0}};
    localparam logic [LGMAXOUT:0] MAXOUT     = {1'b0, {LGMAXOUT{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_ABORT  = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [LGMAXOUT:0] count_r, count_s;
    logic [TW-1:0]     timer_r, timer_s;
    logic              live_s, full_s, fwd_stb_s, accept_s;
    logic              ack_s, err_s, stall_s, progress_s;

    // State, outstanding count and no-progress timer registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r <= S_IDLE;
            count_r <= CNT_ZERO;
            timer_r <= TIMER_ZERO;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            timer_r <= timer_s;
        end
    end

    // Forwarding decisions, response gating and next-state/count/timer computation
    always_comb begin
        state_s    = state_r;
        count_s    = count_r;
        timer_s    = timer_r;
        live_s     = 1'b0;
        fwd_stb_s  = 1'b0;
        accept_s   = 1'b0;
        ack_s      = 1'b0;
        err_s      = 1'b0;
        stall_s    = 1'b0;
        progress_s = 1'b0;
        full_s     = (count_r == MAXOUT);
        case (state_r)
            S_IDLE, S_ACTIVE: begin
                if (i_wb_cyc) begin
                    live_s    = 1'b1;
                    fwd_stb_s = i_wb_stb && !full_s;
                    accept_s  = fwd_stb_s && !i_dn_stall;
                    stall_s   = i_dn_stall || full_s;
                    // A response only counts if it can match a request still in flight
                    if (count_r != CNT_ZERO) begin
                        err_s = i_dn_err;
                        ack_s = i_dn_ack && !i_dn_err;
                    end else begin
                        err_s = 1'b0;
                        ack_s = 1'b0;
                    end
                    progress_s = accept_s || ack_s || err_s ||
                                 ((count_r == CNT_ZERO) && !i_wb_stb);
                    if (err_s) begin
                        state_s = S_IDLE;
                        count_s = CNT_ZERO;
                        timer_s = TIMER_ZERO;
                    end else if (progress_s) begin
                        state_s = S_ACTIVE;
                        timer_s = TIMER_ZERO;
                        count_s = count_r + {{LGMAXOUT{1'b0}}, accept_s}
                                          - {{LGMAXOUT{1'b0}}, ack_s};
                    end else if (timer_r == TIMER_LAST) begin
                        state_s = S_ABORT;
                        count_s = CNT_ZERO;
                        timer_s = TIMER_ZERO;
                    end else begin
                        state_s = S_ACTIVE;
                        timer_s = timer_r + TIMER_ONE;
                    end
                end else begin
                    state_s = S_IDLE;
                    count_s = CNT_ZERO;
                    timer_s = TIMER_ZERO;
                end
            end
            S_ABORT: begin
                stall_s = 1'b1;
                err_s   = i_wb_cyc;
                count_s = CNT_ZERO;
                timer_s = TIMER_ZERO;
                if (i_wb_cyc) begin
                    state_s = S_DRAIN;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_DRAIN: begin
                stall_s = 1'b1;
                count_s = CNT_ZERO;
                timer_s = TIMER_ZERO;
                if (i_wb_cyc) begin
                    state_s = S_DRAIN;
                end else begin
                    state_s = S_IDLE;
                end
            end
            default: begin
                state_s = S_IDLE;
                count_s = CNT_ZERO;
                timer_s = TIMER_ZERO;
            end
        endcase
    end

    // Reset forces every output low at once, even while the upstream still holds cyc
    assign o_dn_cyc      = live_s && !i_reset;
    assign o_dn_stb      = fwd_stb_s && !i_reset;
    assign o_dn_we       = i_wb_we && !i_reset;
    assign o_dn_addr     = i_reset ? {AW{1'b0}} : i_wb_addr;
    assign o_dn_data     = i_reset ? {DW{1'b0}} : i_wb_data;
    assign o_dn_sel      = i_reset ? {(DW/8){1'b0}} : i_wb_sel;
    assign o_wb_stall    = stall_s && !i_reset;
    assign o_wb_ack      = ack_s && !i_reset;
    assign o_wb_err      = err_s && !i_reset;
    assign o_wb_data     = i_reset ? {DW{1'b0}} : i_dn_data;
    assign o_timeout     = (state_r == S_ABORT) && !i_reset;
    assign o_outstanding = count_r;

    wbp_watchdog_checker #(
        .CW   (LGMAXOUT + 1),
        .MAXC (MAXOUT)
    ) u_checker (
        .clk     (i_clk),
        .rst     (i_reset),
        .cyc     (i_wb_cyc),
        .ack     (o_wb_ack),
        .err     (o_wb_err),
        .timeout (o_timeout),
        .dn_cyc  (o_dn_cyc),
        .count   (o_outstanding)
    );

endmodule

// File: tb/tb_wbp_watchdog.sv
// Directed plus randomized bench for wbp_watchdog, checked against a transaction-level
// model of the guard (mode, outstanding count, consecutive no-progress clocks).

module tb_wbp_watchdog;

    localparam int AW     = 26;
    localparam int DW     = 32;
    localparam int LG     = 4;
    localparam int TO     = 8;
    localparam int MAXOUT = 15;

    logic            clk = 1'b0;
    logic            rst;
    logic            cyc, stb, we;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] sel;
    logic            dstall, dack, derr;
    logic [DW-1:0]   ddata;
    logic            o_wb_stall, o_wb_ack, o_wb_err, o_dn_cyc, o_dn_stb, o_dn_we, o_timeout;
    logic [DW-1:0]   o_wb_data, o_dn_data;
    logic [AW-1:0]   o_dn_addr;
    logic [DW/8-1:0] o_dn_sel;
    logic [LG:0]     o_outstanding;

    always #5 clk = ~clk;

    wbp_watchdog #(.AW(AW), .DW(DW), .LGMAXOUT(LG), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
        .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_data(o_wb_data), .o_wb_err(o_wb_err),
        .o_dn_cyc(o_dn_cyc), .o_dn_stb(o_dn_stb), .o_dn_we(o_dn_we),
        .o_dn_addr(o_dn_addr), .o_dn_data(o_dn_data), .o_dn_sel(o_dn_sel),
        .i_dn_stall(dstall), .i_dn_ack(dack), .i_dn_err(derr), .i_dn_data(ddata),
        .o_timeout(o_timeout), .o_outstanding(o_outstanding)
    );

    typedef struct {
        int          due;
        logic [DW-1:0] data;
    } rsp_t;

    int checks = 0;
    int errors = 0;

    // model: mode 0 idle, 1 active, 2 abort, 3 drain
    int mode, cnt, quiet;
    bit e_live, e_stb, e_acc, e_stall, e_ack, e_err, e_to;
    rsp_t sq[$];
    logic [DW-1:0] uq[$];

    bit slave_on, fixed_on;
    logic [DW-1:0] fixed_data;
    int dly_lo, dly_hi, long_pct, err_pct, spur_pct;
    int cyc_n = 0;

    bit last_ack, last_err, last_to, last_dncyc, last_acc, last_stall;
    logic [DW-1:0] last_data;
    int last_out, acks_seen, timeouts_seen, max_out;
    bit stall_full_seen;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mode = 0; cnt = 0; quiet = 0;
        sq.delete(); uq.delete();
    endtask

    // One clock: slave response, mid-cycle comparison, then model advance at the edge
    task automatic tick();
        rsp_t r;
        logic [DW-1:0] d;
        if (slave_on) begin
            if (sq.size() > 0 && sq[0].due <= cyc_n) begin
                dack = 1'b1;
                ddata = sq[0].data;
                derr = (int'($urandom_range(99)) < err_pct);
                void'(sq.pop_front());
            end else begin
                dack = (sq.size() == 0) && (cnt == 0) && (int'($urandom_range(99)) < spur_pct);
                derr = 1'b0;
                ddata = $urandom;
            end
        end
        #4;
        e_live  = (mode <= 1) && cyc;
        e_stb   = e_live && stb && (cnt < MAXOUT);
        e_acc   = e_stb && !dstall;
        e_stall = e_live ? (dstall || cnt == MAXOUT) : (mode >= 2);
        e_err   = (mode == 2 && cyc) || (e_live && cnt > 0 && derr);
        e_ack   = e_live && cnt > 0 && dack && !derr;
        e_to    = (mode == 2);
        check("ctl", {o_dn_cyc, o_dn_stb, o_wb_stall, o_wb_ack, o_wb_err, o_timeout, o_outstanding},
                     {e_live, e_stb, e_stall, e_ack, e_err, e_to, 5'(cnt)});
        check("pass", {o_dn_we, o_dn_sel, o_dn_data, o_dn_addr}, {we, sel, wdata, addr});
        last_ack = o_wb_ack; last_err = o_wb_err; last_to = o_timeout; last_dncyc = o_dn_cyc;
        last_data = o_wb_data; last_out = int'(o_outstanding); last_acc = e_acc; last_stall = o_wb_stall;
        if (o_wb_ack) acks_seen++;
        if (o_timeout) timeouts_seen++;
        if (int'(o_outstanding) > max_out) max_out = int'(o_outstanding);
        if (o_wb_stall && int'(o_outstanding) == MAXOUT && !dstall) stall_full_seen = 1'b1;
        if (e_acc) begin
            d = fixed_on ? fixed_data : {addr, 6'h2a};
            r.due = cyc_n + ((int'($urandom_range(99)) < long_pct) ? 12
                             : int'($urandom_range(dly_hi, dly_lo)));
            r.data = d;
            sq.push_back(r);
            uq.push_back(d);
        end
        if (e_ack && uq.size() > 0) check("rdata_order", o_wb_data, uq.pop_front());
        @(posedge clk);
        if (mode <= 1) begin
            if (!cyc || e_err) begin
                mode = 0; cnt = 0; quiet = 0;
            end else if (e_acc || e_ack || (cnt == 0 && !stb)) begin
                cnt = cnt + int'(e_acc) - int'(e_ack);
                quiet = 0; mode = 1;
            end else begin
                quiet++;
                mode = (quiet == TO) ? 2 : 1;
                if (mode == 2) begin cnt = 0; quiet = 0; end
            end
        end else begin
            mode = cyc ? 3 : 0;
            cnt = 0; quiet = 0;
        end
        if (mode >= 2 || mode == 0 || e_err) begin
            sq.delete(); uq.delete();
        end
        cyc_n++;
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int n0, issued, a0, t0;
        rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b1;
        addr = 26'h3ABCDEF; wdata = 32'h12345678; sel = 4'hF;
        dstall = 1'b0; dack = 1'b1; derr = 1'b0; ddata = 32'hCAFEF00D;
        slave_on = 1'b0; fixed_on = 1'b0; fixed_data = 32'h0;
        dly_lo = 1; dly_hi = 1; long_pct = 0; err_pct = 0; spur_pct = 0;
        acks_seen = 0; timeouts_seen = 0; max_out = 0; stall_full_seen = 1'b0;
        #3;
        check("rst_ctl", {o_dn_cyc, o_dn_stb, o_dn_we, o_wb_stall, o_wb_ack, o_wb_err, o_timeout, o_outstanding}, 64'd0);
        check("rst_bus", {o_dn_addr, o_dn_sel}, 64'd0);
        check("rst_data", {o_dn_data, o_wb_data}, 64'd0);
        cyc = 1'b0; stb = 1'b0; dack = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        model_reset();

        // single read answered two clocks after acceptance
        fixed_on = 1'b1; fixed_data = 32'hDEADBEEF; t0 = timeouts_seen;
        cyc = 1'b1; stb = 1'b1; addr = 26'($urandom);
        tick(); check("t1_out_before", last_out, 0);
        stb = 1'b0;
        tick(); check("t1_out_pending", last_out, 1);
        dack = 1'b1; ddata = 32'hDEADBEEF;
        tick(); check("t1_ack", last_ack, 1); check("t1_data", last_data, 32'hDEADBEEF);
        dack = 1'b0;
        tick(); check("t1_out_after", last_out, 0);
        check("t1_no_timeout", timeouts_seen, t0);
        cyc = 1'b0; tick();

        // pipelined burst of 20 with 16-clock slave latency
        slave_on = 1'b1; fixed_on = 1'b0; dly_lo = 16; dly_hi = 16;
        max_out = 0; stall_full_seen = 1'b0; a0 = acks_seen; t0 = timeouts_seen; issued = 0;
        cyc = 1'b1;
        for (int k = 0; k < 200 && issued < 20; k++) begin
            stb = 1'b1; addr = 26'($urandom);
            tick();
            if (last_acc) issued++;
        end
        stb = 1'b0;
        for (int k = 0; k < 100 && uq.size() > 0; k++) tick();
        check("t2_issued", issued, 20);
        check("t2_acks", acks_seen - a0, 20);
        check("t2_max_count", max_out, MAXOUT);
        check("t2_stall_at_full", stall_full_seen, 1);
        check("t2_no_timeout", timeouts_seen, t0);
        cyc = 1'b0; tick();

        // timeout on a request that is never answered
        slave_on = 1'b0; dack = 1'b0; derr = 1'b0;
        cyc = 1'b1; stb = 1'b1; addr = 26'($urandom);
        n0 = cyc_n;
        tick();
        stb = 1'b0;
        for (int k = 0; k < 20 && !last_to; k++) tick();
        check("t3_timeout", last_to, 1);
        // abort lands eight edges after the accepting edge
        check("t3_latency", (cyc_n - 1) - n0, TO + 1);
        check("t3_err", {last_err, last_ack, last_dncyc}, 3'b100);
        dack = 1'b1;
        tick(); check("t3_drain_ack", {last_ack, last_err, last_stall}, 3'b001);
        check("t3_count", last_out, 0);
        dack = 1'b0; cyc = 1'b0; tick();

        // request held off by a permanently stalled slave
        dstall = 1'b1; cyc = 1'b1; stb = 1'b1;
        n0 = cyc_n;
        for (int k = 0; k < 20 && !last_to; k++) tick();
        check("t4_timeout", last_to, 1);
        check("t4_latency", (cyc_n - 1) - n0, TO);
        check("t4_count", last_out, 0);
        dstall = 1'b0; stb = 1'b0; cyc = 1'b0; tick();

        // spurious ack, then ack coinciding with a new request
        fixed_on = 1'b1; fixed_data = 32'h0BADF00D;
        cyc = 1'b1; stb = 1'b0; dack = 1'b1; ddata = 32'h11111111;
        tick(); check("t5_spurious", {last_ack, last_err}, 2'b00);
        check("t5_out0", last_out, 0);
        dack = 1'b0; stb = 1'b1;
        tick();
        dack = 1'b1; ddata = 32'h0BADF00D;
        tick(); check("t5_ack", last_ack, 1);
        dack = 1'b0; stb = 1'b0;
        tick(); check("t5_out_same", last_out, 1);
        dack = 1'b1;
        tick(); dack = 1'b0; cyc = 1'b0;
        tick(); check("t5_out_end", last_out, 0);

        // reset pulse with three requests outstanding
        slave_on = 1'b1; fixed_on = 1'b0; dly_lo = 30; dly_hi = 30;
        cyc = 1'b1; stb = 1'b1;
        for (int k = 0; k < 3; k++) begin addr = 26'($urandom); tick(); end
        stb = 1'b0;
        tick(); check("t6_out3", last_out, 3);
        #2; stb = 1'b1; rst = 1'b1; #1;
        check("t6_ctl", {o_dn_cyc, o_dn_stb, o_dn_we, o_wb_stall, o_wb_ack, o_wb_err, o_timeout, o_outstanding}, 64'd0);
        check("t6_addr", o_dn_addr, 26'd0);
        @(posedge clk); #1;
        rst = 1'b0; model_reset(); cyc_n++;
        cyc = 1'b0; stb = 1'b0;
        tick(); check("t6_idle", {last_dncyc, last_out[4:0]}, 6'd0);

        // randomized traffic against the model
        dly_lo = 1; dly_hi = 5; long_pct = 10; err_pct = 3; spur_pct = 20;
        for (int k = 0; k < 800; k++) begin
            cyc = (int'($urandom_range(29)) != 0);
            stb = 1'($urandom_range(1));
            we = 1'($urandom_range(1));
            addr = 26'($urandom); wdata = $urandom; sel = 4'($urandom);
            dstall = (int'($urandom_range(3)) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
